// File: rtl/cmp_share_arbiter.sv
// Two-port round-robin front end to one shared SLT/SLTU comparator.
// Requests are registered in S1, compared there, and the result is registered in S2 (2-cycle latency).
module cmp_share_arbiter #(
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_unsigned,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_unsigned,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_result,
    output logic        busy
);

    logic        r_last_grant;
    logic        r_s1_valid;
    logic        r_s1_id;
    logic [31:0] r_s1_a;
    logic [31:0] r_s1_b;
    logic        r_s1_unsigned;
    logic        r_s2_valid;
    logic        r_s2_id;
    logic        r_s2_lt;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_hs;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_unsigned;
    logic [32:0] w_diff;
    logic        w_lt;

    // On a conflict the port that did not win last time goes next.
    always_comb begin
        w_grant0   = ~rst & ~flush & req0_valid & (~req1_valid | r_last_grant);
        w_grant1   = ~rst & ~flush & req1_valid & (~req0_valid | ~r_last_grant);
        w_hs       = w_grant0 | w_grant1;
        w_a        = w_grant1 ? req1_a : req0_a;
        w_b        = w_grant1 ? req1_b : req0_b;
        w_unsigned = w_grant1 ? req1_unsigned : req0_unsigned;
    end

    // A - B via A + ~B + 1; carry-out clear means a borrow occurred.
    always_comb begin
        w_diff = {1'b0, r_s1_a} + {1'b0, ~r_s1_b} + 33'd1;
        if (r_s1_unsigned) begin
            w_lt = ~w_diff[32];
        end else if (r_s1_a[31] != r_s1_b[31]) begin
            w_lt = r_s1_a[31];
        end else begin
            w_lt = w_diff[31];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant  <= ~RESET_PRIO;
            r_s1_valid    <= 1'b0;
            r_s1_id       <= 1'b0;
            r_s1_a        <= 32'd0;
            r_s1_b        <= 32'd0;
            r_s1_unsigned <= 1'b0;
            r_s2_valid    <= 1'b0;
            r_s2_id       <= 1'b0;
            r_s2_lt       <= 1'b0;
        end else begin
            r_s1_valid <= w_hs;
            if (w_hs) begin
                r_last_grant  <= w_grant1;
                r_s1_id       <= w_grant1;
                r_s1_a        <= w_a;
                r_s1_b        <= w_b;
                r_s1_unsigned <= w_unsigned;
            end
            // Flush kills the S1 entry; the S2 entry visible now still completes.
            r_s2_valid <= r_s1_valid & ~flush;
            r_s2_id    <= r_s1_id;
            r_s2_lt    <= w_lt;
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp0_valid = r_s2_valid & ~r_s2_id;
    assign rsp1_valid = r_s2_valid & r_s2_id;
    assign rsp_result = {31'd0, r_s2_valid & r_s2_lt};
    assign busy       = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Drives two instances (RESET_PRIO 0 and 1) with identical stimulus and checks both
// against a due-cycle scoreboard built from the comparison and arbitration rules.
module tb_cmp_share_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        v0, v1, u0, u1;
    logic [31:0] a0, b0, a1, b1;

    logic [1:0]  rdy0, rdy1, rsp0, rsp1, bsy;
    logic [31:0] res [2];

    int n_total = 0;
    int n_bad   = 0;

    // Scoreboard: slot (due cycle % 4) holds the response expected in that cycle.
    logic        sb_v   [2][4];
    logic        sb_p   [2][4];
    logic        sb_lt  [2][4];
    logic        m_last [2];
    int          cyc = 0;

    cmp_share_arbiter #(.RESET_PRIO(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_unsigned(u0), .req0_ready(rdy0[0]),
        .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_unsigned(u1), .req1_ready(rdy1[0]),
        .rsp0_valid(rsp0[0]), .rsp1_valid(rsp1[0]), .rsp_result(res[0]), .busy(bsy[0])
    );

    cmp_share_arbiter #(.RESET_PRIO(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_unsigned(u0), .req0_ready(rdy0[1]),
        .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_unsigned(u1), .req1_ready(rdy1[1]),
        .rsp0_valid(rsp0[1]), .rsp1_valid(rsp1[1]), .rsp_result(res[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b, input logic u);
        if (u) return (a < b);
        return ($signed(a) < $signed(b));
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            m_last[k] = (k == 0) ? 1'b1 : 1'b0;
            for (int s = 0; s < 4; s++) begin
                sb_v[k][s]  = 1'b0;
                sb_p[k][s]  = 1'b0;
                sb_lt[k][s] = 1'b0;
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_ready0", k), {31'd0, rdy0[k]}, 32'd0);
            chk($sformatf("rst%0d_ready1", k), {31'd0, rdy1[k]}, 32'd0);
            chk($sformatf("rst%0d_rsp0", k), {31'd0, rsp0[k]}, 32'd0);
            chk($sformatf("rst%0d_rsp1", k), {31'd0, rsp1[k]}, 32'd0);
            chk($sformatf("rst%0d_result", k), res[k], 32'd0);
            chk($sformatf("rst%0d_busy", k), {31'd0, bsy[k]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; flush = 1'b0;
        model_clear();
        $display("reset applied at cycle %0d", cyc);
    endtask

    task automatic step(input logic iv0, input logic [31:0] ia0, input logic [31:0] ib0, input logic iu0,
                        input logic iv1, input logic [31:0] ia1, input logic [31:0] ib1, input logic iu1,
                        input logic ifl);
        logic g0, g1, ev, ep, elt, nb;
        int   s0, s1, s2;
        @(negedge clk);
        v0 = iv0; a0 = ia0; b0 = ib0; u0 = iu0;
        v1 = iv1; a1 = ia1; b1 = ib1; u1 = iu1;
        flush = ifl;
        #1;
        s0 = cyc % 4; s1 = (cyc + 1) % 4; s2 = (cyc + 2) % 4;
        for (int k = 0; k < 2; k++) begin
            g0 = !ifl && iv0 && (!iv1 || m_last[k] == 1'b1);
            g1 = !ifl && iv1 && (!iv0 || m_last[k] == 1'b0);
            ev = sb_v[k][s0]; ep = sb_p[k][s0]; elt = sb_lt[k][s0];
            nb = sb_v[k][s0] || sb_v[k][s1];
            chk($sformatf("i%0d_ready0", k), {31'd0, rdy0[k]}, {31'd0, g0});
            chk($sformatf("i%0d_ready1", k), {31'd0, rdy1[k]}, {31'd0, g1});
            chk($sformatf("i%0d_rsp0", k), {31'd0, rsp0[k]}, {31'd0, ev && !ep});
            chk($sformatf("i%0d_rsp1", k), {31'd0, rsp1[k]}, {31'd0, ev && ep});
            chk($sformatf("i%0d_result", k), res[k], {31'd0, ev && elt});
            chk($sformatf("i%0d_busy", k), {31'd0, bsy[k]}, {31'd0, nb});
            sb_v[k][s0] = 1'b0;
            if (ifl) sb_v[k][s1] = 1'b0;
            if (g0) begin
                sb_v[k][s2] = 1'b1; sb_p[k][s2] = 1'b0; sb_lt[k][s2] = ref_lt(ia0, ib0, iu0);
                m_last[k] = 1'b0;
            end
            if (g1) begin
                sb_v[k][s2] = 1'b1; sb_p[k][s2] = 1'b1; sb_lt[k][s2] = ref_lt(ia1, ib1, iu1);
                m_last[k] = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'd0;
            4: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] bnd_a [8];
    logic [31:0] bnd_b [8];
    logic        bnd_u [8];

    initial begin
        logic [31:0] ra0, rb0, ra1, rb1;
        rst = 1'b1; flush = 1'b0;
        v0 = 0; v1 = 0; u0 = 0; u1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        model_clear();
        do_reset();

        bnd_a = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'd0, 32'd0, 32'd5, 32'h7FFF_FFFF};
        bnd_b = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000};
        bnd_u = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            $display("boundary %0d: a=0x%08h b=0x%08h unsigned=%0d", i, bnd_a[i], bnd_b[i], bnd_u[i]);
            step(1, bnd_a[i], bnd_b[i], bnd_u[i], 0, 0, 0, 0, 0);
            idle(2);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, bnd_a[i], bnd_b[i], bnd_u[i], 0);
        idle(3);

        // Two-way conflict straight out of reset.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 32'd1, 32'd2, 0, 1, 32'd3, 32'd2, 0, 0);
        idle(3);
        $display("conflict sequence done at cycle %0d", cyc);

        // Flush drops the S1 entry but not the S2 one.
        step(0, 0, 0, 0, 1, 32'd1, 32'd9, 0, 0);
        step(1, 32'd1, 32'd9, 0, 0, 0, 0, 0, 0);
        step(1, 32'd1, 32'd9, 0, 1, 32'd1, 32'd9, 0, 1);
        idle(3);
        $display("flush sequence done at cycle %0d", cyc);

        // Asynchronous reset with both stages full, then a conflict.
        for (int i = 0; i < 3; i++) step(1, 32'd4, 32'd8, 1, 1, 32'd8, 32'd4, 1, 0);
        do_reset();
        step(1, 32'd4, 32'd8, 1, 1, 32'd8, 32'd4, 1, 0);
        step(1, 32'd4, 32'd8, 1, 1, 32'd8, 32'd4, 1, 0);
        idle(3);

        for (int i = 0; i < 10000; i++) begin
            ra0 = rnd_op(); rb0 = ($urandom_range(0, 7) == 0) ? ra0 : rnd_op();
            ra1 = rnd_op(); rb1 = ($urandom_range(0, 7) == 0) ? ra1 : rnd_op();
            step($urandom_range(0, 9) < 7, ra0, rb0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 7, ra1, rb1, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 19) == 0);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
